// File: rtl/stat_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | stat_seq_ctrl: tick-paced switch capture and statistics datapath control |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stat_seq_ctrl #(
  parameter int unsigned TICK_CYCLES = 1_000_000_000,
  parameter int unsigned MAX_N       = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  output logic       dp_clr,
  output logic       dp_load,
  output logic [7:0] dp_data,
  output logic       dp_start,
  output logic [1:0] dp_op,
  output logic [7:0] dp_n,
  input  logic       dp_done,
  input  logic [7:0] dp_result,
  output logic [7:0] led,
  output logic [2:0] state_o,
  output logic       busy
);

  localparam int unsigned     CNT_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [7:0]       MAX_N_B   = 8'(MAX_N);

  typedef enum logic [2:0] {
    S_GET_N    = 3'd0,
    S_GET_DATA = 3'd1,
    S_GET_OP   = 3'd2,
    S_WAIT     = 3'd3,
    S_SHOW     = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [7:0]       n_q, n_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       led_q, led_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       dpn_q, dpn_d;
  logic             clr_q, clr_d;
  logic             load_q, load_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;

  // Free-running sample tick; the strobe decodes the terminal count.
  assign tick  = (cnt_q == TICK_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    led_d   = led_q;
    data_d  = data_q;
    op_d    = op_q;
    dpn_d   = dpn_q;
    clr_d   = 1'b0;
    load_d  = 1'b0;
    start_d = 1'b0;

    case (state_q)
      S_GET_N: begin
        if (tick) begin
          n_d   = sw;
          led_d = sw;
          if ((sw == 8'd0) || (sw > MAX_N_B)) begin
            led_d   = 8'hFF;
            state_d = S_ERR;
          end else begin
            clr_d   = 1'b1;
            idx_d   = 8'd0;
            dpn_d   = sw;
            state_d = S_GET_DATA;
          end
        end
      end
      S_GET_DATA: begin
        if (tick) begin
          load_d = 1'b1;
          data_d = sw;
          led_d  = sw;
          idx_d  = idx_q + 8'd1;
          if (idx_q == (n_q - 8'd1)) begin
            state_d = S_GET_OP;
          end
        end
      end
      S_GET_OP: begin
        if (tick) begin
          op_d    = (sw >= 8'd3) ? 2'd3 : sw[1:0];
          led_d   = sw;
          start_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      // Completion wins over a coincident tick, which is simply dropped.
      S_WAIT: begin
        if (dp_done) begin
          led_d   = dp_result;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (tick) begin
          state_d = S_GET_N;
        end
      end
      S_ERR: begin
        led_d = 8'hFF;
        if (tick) begin
          state_d = S_GET_N;
        end
      end
      default: begin
        state_d = S_GET_N;
      end
    endcase

    busy_d = (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GET_N;
      cnt_q   <= '0;
      n_q     <= 8'd0;
      idx_q   <= 8'd0;
      led_q   <= 8'd0;
      data_q  <= 8'd0;
      op_q    <= 2'd0;
      dpn_q   <= 8'd0;
      clr_q   <= 1'b0;
      load_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      data_q  <= data_d;
      op_q    <= op_d;
      dpn_q   <= dpn_d;
      clr_q   <= clr_d;
      load_q  <= load_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign dp_clr   = clr_q;
  assign dp_load  = load_q;
  assign dp_data  = data_q;
  assign dp_start = start_q;
  assign dp_op    = op_q;
  assign dp_n     = dpn_q;
  assign led      = led_q;
  assign state_o  = state_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: doc/stat_seq_ctrl.md
# stat_seq_ctrl

Sequencing controller for the switch-driven statistics datapath (sum / mean / sum of squares / standard deviation). It paces operator input with a fixed sample tick and captures the item count N, then N data bytes, then an operation code from the 8 switches. It drives clear/load/start strobes into the external statistics datapath, waits for its completion handshake and routes the result to the LEDs. It sits between the board switches/LEDs and the arithmetic datapath, which contains no timing or control logic of its own.

## Interface
- TICK_CYCLES, 1_000_000_000: clock cycles per sample tick (10 s at 100 MHz); must be ≥ 2
- MAX_N, 10: largest legal item count; must be 1..255
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- sw  in  8  operator switch value, sampled only on tick
- dp_clr  out  1  one-cycle pulse: clear datapath accumulators
- dp_load  out  1  one-cycle pulse: accumulate dp_data
- dp_data  out  8  data byte; valid while dp_load=1, otherwise holds last value
- dp_start  out  1  one-cycle pulse: begin operation dp_op over N items
- dp_op  out  2  0=sum, 1=mean, 2=sum of squares, 3=std deviation; stable from dp_start until dp_done
- dp_n  out  8  captured item count; stable from dp_clr until the next GET_N capture
- dp_done  in  1  datapath completion pulse, honoured only in WAIT
- dp_result  in  8  datapath result, valid in the dp_done cycle
- led  out  8  display value
- state_o  out  3  current state encoding
- busy  out  1  high while in WAIT

## Operation
- Tick generator: counter 0..TICK_CYCLES-1, free-running from reset. tick=1 (combinational) when counter==TICK_CYCLES-1, then wraps to 0. First tick is at the TICK_CYCLES-th rising edge after rst_n deasserts.
- States and encodings: GET_N=0, GET_DATA=1, GET_OP=2, WAIT=3, SHOW=4, ERR=5. Other encodings go to GET_N on the next edge.
- GET_N, on tick:
  - n_reg←sw, led←sw.
  - If sw==0 or sw>MAX_N: go to ERR.
  - Otherwise pulse dp_clr, set idx←0, dp_n←sw, go to GET_DATA.
- GET_DATA, on tick:
  - Pulse dp_load with dp_data←sw, led←sw, idx←idx+1.
  - When the load is number n_reg (idx==n_reg-1 before increment), go to GET_OP; otherwise stay.
- GET_OP, on tick:
  - dp_op←(sw≥3 ? 3 : sw[1:0]), led←sw, pulse dp_start, go to WAIT.
- WAIT:
  - Ticks are ignored.
  - On dp_done: led←dp_result, go to SHOW.
  - No timeout; the controller waits indefinitely.
- SHOW: led holds the result. On tick, go to GET_N; led keeps the result until the next GET_N capture.
- ERR: led=8'hFF. On tick, go to GET_N without capturing (sw is re-sampled on the following tick).
- dp_done outside WAIT is ignored and causes no state change.
- idx is 8 bits and never wraps, because n_reg ≤ MAX_N ≤ 255.

## Timing
- Every output is a registered flop; there are no combinational input→output paths.
- Tick in cycle k gives the resulting strobe, led and state updates at the edge ending cycle k, so they are visible in cycle k+1.
- Each strobe is exactly one cycle wide. At most one strobe is active per cycle.
- dp_done in cycle k: led=dp_result and state_o=SHOW in cycle k+1, and busy drops in cycle k+1.
- dp_done and tick in the same WAIT cycle: dp_done is handled and the tick is discarded.
- Reset values (asynchronous, while rst_n=0):
  - state GET_N, counter 0, idx 0, n_reg 0
  - led=0, dp_data=0, dp_op=0, dp_n=0
  - all strobes 0, busy=0
- Reset mid-sequence aborts at once with no strobe, and capture restarts from GET_N.
- The datapath must not be relied on across a reset; the next dp_clr reinitialises it.
- Minimum sequence length: N+2 ticks plus datapath latency, then 1 more tick to leave SHOW.

## Test plan
- TICK_CYCLES=4, MAX_N=10, reset released at edge 0 -> first tick at edge 4. Check all reset values; dp_clr pulses one cycle after the GET_N tick.
- sw=3, then 10, 20, 30, then op 0; datapath model returns 60 after 5 cycles:
  - three dp_load pulses carrying 10, 20, 30
  - dp_start with dp_op=0
  - busy high for 5 cycles, then led=60 and state_o=4
- sw=0 at GET_N -> state ERR and led=8'hFF. The next tick returns to GET_N; the following tick with sw=2 starts a valid sequence.
- sw=11 at GET_N (> MAX_N) -> ERR, no dp_clr. At GET_OP, sw=7 -> dp_op=3.
- In WAIT, hold ticks for 3 periods with no dp_done -> no state change and no strobes. Then dp_done coincident with a tick -> SHOW with led=dp_result.
- Assert rst_n=0 mid-GET_DATA after 2 of 4 loads -> outputs reset asynchronously, no further dp_load. Capture restarts from GET_N, and a spurious dp_done pulse while in GET_N is ignored.
